// File: rtl/pending_priority_encoder_16x4.sv
// Registered 16-to-4 priority encoder with rising-edge pending capture.
// The highest pending line is presented as a code and held until the consumer acks it.
module pending_priority_encoder_16x4 #(
   parameter int unsigned N_LINES = 16,
   parameter int unsigned ADDR_W  = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic [N_LINES-1:0] D,
   input  logic               ack,
   output logic [ADDR_W-1:0]  A,
   output logic               valid,
   output logic               overrun,
   output logic [N_LINES-1:0] pending
);

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [N_LINES-1:0]   r_d_q;
   logic [N_LINES-1:0]   r_pending;
   logic [ADDR_W-1:0]    r_a;
   logic                 r_valid;
   logic                 r_overrun;

   logic [N_LINES-1:0]   w_rise;
   logic [N_LINES-1:0]   w_set;
   logic [N_LINES-1:0]   w_clr;
   logic [ADDR_W-1:0]    w_top;
   logic                 w_present;
   logic                 w_load_a;
   logic                 w_valid_nxt;

   assign w_rise    = D & ~r_d_q;
   assign w_set     = enable ? w_rise : '0;
   assign w_present = enable && (r_pending != '0);

   // Highest-index pending line wins; later iterations override earlier ones
   always_comb begin
      w_top = '0;
      for (int i = 0; i < int'(N_LINES); i++) begin
         if (r_pending[i]) w_top = ADDR_W'(i);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_present) w_state_nxt = S_HOLD;
         S_HOLD:  if (ack)       w_state_nxt = S_IDLE;
         default:                w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_load_a    = 1'b0;
      w_valid_nxt = 1'b0;
      w_clr       = '0;
      case (r_state)
         S_IDLE: begin
            w_load_a    = w_present;
            w_valid_nxt = w_present;
         end
         S_HOLD: begin
            w_valid_nxt = ~ack;
            if (ack) w_clr = N_LINES'(1) << r_a;
         end
         default: ;
      endcase
   end

   // Set is applied after clear so a rise coinciding with ack keeps the line pending
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_d_q     <= '0;
         r_pending <= '0;
         r_a       <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_d_q     <= D;
         r_pending <= (r_pending & ~w_clr) | w_set;
         r_overrun <= enable & (|(w_rise & r_pending));
         r_valid   <= w_valid_nxt;
         if (w_load_a) r_a <= w_top;
      end
   end

   assign A       = r_a;
   assign valid   = r_valid;
   assign overrun = r_overrun;
   assign pending = r_pending;

endmodule

// File: tb/tb_pending_priority_encoder_16x4.sv
// Bench for pending_priority_encoder_16x4: directed scenarios plus random traffic,
// every cycle compared against an event-queue style reference model.
module tb_pending_priority_encoder_16x4;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [15:0] D;
   logic        ack;
   logic [3:0]  A;
   logic        valid;
   logic        overrun;
   logic [15:0] pending;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: set of waiting lines, the line being served, last input levels
   bit        m_wait [16];
   bit        m_prev [16];
   bit        m_busy;
   int        m_code;
   bit        m_ov;

   pending_priority_encoder_16x4 dut (
      .clk     (clk),
      .reset   (reset),
      .enable  (enable),
      .D       (D),
      .ack     (ack),
      .A       (A),
      .valid   (valid),
      .overrun (overrun),
      .pending (pending)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] model_pending();
      logic [15:0] v;
      for (int i = 0; i < 16; i++) v[i] = m_wait[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_wait[i] = 0;
         m_prev[i] = 0;
      end
      m_busy = 0;
      m_code = 0;
      m_ov   = 0;
   endtask

   // One clock of the reference behaviour, computed from the inputs seen at the edge
   task automatic model_edge(input bit en, input logic [15:0] d, input bit ak);
      bit old_wait [16];
      bit rose;
      int best;
      old_wait = m_wait;
      m_ov = 0;
      if (m_busy && ak) m_wait[m_code] = 0;
      for (int i = 0; i < 16; i++) begin
         rose = d[i] && !m_prev[i];
         if (en && rose) begin
            if (old_wait[i]) m_ov = 1;
            m_wait[i] = 1;
         end
         m_prev[i] = d[i];
      end
      if (m_busy) begin
         if (ak) m_busy = 0;
      end else if (en) begin
         best = -1;
         for (int i = 15; i >= 0; i--) begin
            if (old_wait[i] && best < 0) best = i;
         end
         if (best >= 0) begin
            m_code = best;
            m_busy = 1;
         end
      end
   endtask

   task automatic compare_all();
      check("valid",   32'(valid),   32'(m_busy));
      check("A",       32'(A),       32'(m_code));
      check("pending", 32'(pending), 32'(model_pending()));
      check("overrun", 32'(overrun), 32'(m_ov));
   endtask

   task automatic step(input bit en, input logic [15:0] d, input bit ak);
      enable = en;
      D      = d;
      ack    = ak;
      @(posedge clk);
      model_edge(en, d, ak);
      #1;
      compare_all();
   endtask

   // Asynchronous reset asserted between edges, observed before the next edge
   task automatic do_reset();
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check("rst_valid",   32'(valid),   32'd0);
      check("rst_A",       32'(A),       32'd0);
      check("rst_pending", 32'(pending), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      logic [15:0] d_rand;
      reset  = 1'b0;
      enable = 1'b0;
      D      = '0;
      ack    = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      do_reset();
      compare_all();

      // Single event on line 5, held without ack, then acked
      step(1, 16'h0020, 0);
      step(1, 16'h0020, 0);
      check("single_A", 32'(A), 32'd5);
      check("single_valid", 32'(valid), 32'd1);
      for (int i = 0; i < 10; i++) step(1, 16'h0020, 0);
      check("single_hold_A", 32'(A), 32'd5);
      step(1, 16'h0000, 1);
      check("single_ack_valid", 32'(valid), 32'd0);
      check("single_ack_pending", 32'(pending), 32'd0);
      step(1, 16'h0000, 0);

      // Priority order 12, 9, 3 with ack tied high
      step(1, 16'h1208, 1);
      for (int i = 0; i < 6; i++) begin
         step(1, 16'h1208, 1);
         if (i % 2 == 0)
            check("prio_code", 32'(A), (i == 0) ? 32'd12 : (i == 2) ? 32'd9 : 32'd3);
         check("prio_valid", 32'(valid), (i % 2 == 0) ? 32'd1 : 32'd0);
      end
      step(1, 16'h0000, 0);

      // HOLD keeps code 2 while 15 becomes pending
      step(1, 16'h0004, 0);
      step(1, 16'h0004, 0);
      step(1, 16'h8004, 0);
      step(1, 16'h8004, 0);
      check("hold_A", 32'(A), 32'd2);
      step(1, 16'h8004, 1);
      step(1, 16'h8004, 0);
      check("hold_next_A", 32'(A), 32'd15);
      step(1, 16'h0000, 1);
      step(1, 16'h0000, 0);

      // Line 7 re-rises in the ack cycle: set wins, overrun pulses
      step(1, 16'h0080, 0);
      step(1, 16'h0080, 0);
      step(1, 16'h0000, 0);
      step(1, 16'h0080, 1);
      check("coll_overrun", 32'(overrun), 32'd1);
      check("coll_pending7", 32'(pending[7]), 32'd1);
      step(1, 16'h0080, 0);
      check("coll_overrun_pulse", 32'(overrun), 32'd0);
      check("coll_represent", 32'(A), 32'd7);
      step(1, 16'h0000, 1);
      step(1, 16'h0000, 0);

      // Enable gating: pulses while disabled and a level held across enable
      step(0, 16'hFFFF, 0);
      step(0, 16'h0000, 0);
      step(0, 16'hFFFF, 0);
      step(1, 16'hFFFF, 0);
      step(1, 16'hFFFF, 0);
      check("gate_pending", 32'(pending), 32'd0);
      check("gate_valid", 32'(valid), 32'd0);
      step(1, 16'h0000, 0);

      // Reset in the middle of a presentation drops everything
      step(1, 16'h0300, 0);
      step(1, 16'h0300, 0);
      do_reset();
      compare_all();

      // Random traffic
      d_rand = '0;
      for (int c = 0; c < 3000; c++) begin
         d_rand = d_rand ^ 16'($urandom & $urandom & $urandom);
         step(($urandom_range(0, 9) != 0), d_rand, ($urandom_range(0, 2) != 0));
         if ($urandom_range(0, 499) == 0) do_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
